// File: rtl/led_status_ctrl_pkg.sv
// Shared definitions for the LED status controller.
// Contents: the channel mode encoding, its 2-bit type, and the index-width
// helper used to size channel selects and internal counters.
package led_ctrl_pkg;

    typedef logic [1:0] led_mode_t;

    localparam led_mode_t MODE_OFF   = 2'd0;
    localparam led_mode_t MODE_ON    = 2'd1;
    localparam led_mode_t MODE_BLINK = 2'd2;
    localparam led_mode_t MODE_PWM   = 2'd3;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_status_ctrl_if.sv
// Configuration port of the LED status controller.
// Write side : wr_en, wr_ch, wr_mode, wr_duty (driven by master),
//              wr_err (one-cycle reject pulse, driven by slave).
// Read side  : rd_ch (driven by master), rd_mode/rd_duty (combinational
//              readback, driven by slave).
interface led_status_ctrl_if import led_ctrl_pkg::*; #(
    parameter int NUM_LEDS = 4,
    parameter int PWM_W    = 8
) ();

    localparam int IDX_W = idx_width(NUM_LEDS);

    logic             wr_en;
    logic [IDX_W-1:0] wr_ch;
    led_mode_t        wr_mode;
    logic [PWM_W-1:0] wr_duty;
    logic             wr_err;
    logic [IDX_W-1:0] rd_ch;
    led_mode_t        rd_mode;
    logic [PWM_W-1:0] rd_duty;

    modport master (
        output wr_en, wr_ch, wr_mode, wr_duty, rd_ch,
        input  wr_err, rd_mode, rd_duty
    );

    modport slave (
        input  wr_en, wr_ch, wr_mode, wr_duty, rd_ch,
        output wr_err, rd_mode, rd_duty
    );

endinterface

// File: rtl/led_status_ctrl_tick_gen.sv
// Timebase for the LED controller.
// Ports: clk, rst_n (async active-low), en (counters hold when 0),
//        tick (one-cycle pulse every PRESCALE enabled cycles),
//        pwm_cnt (free-running PWM_W-bit tick counter),
//        blink_phase (toggles every BLINK_TICKS ticks).
module led_tick_gen import led_ctrl_pkg::*; #(
    parameter int PRESCALE    = 50000,
    parameter int PWM_W       = 8,
    parameter int BLINK_TICKS = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             tick,
    output logic [PWM_W-1:0] pwm_cnt,
    output logic             blink_phase
);

    localparam int PRESC_W = idx_width(PRESCALE);
    localparam int BLINK_W = idx_width(BLINK_TICKS);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic               tick_int;

    // Gated by en so that a disabled controller never emits a tick even
    // while the prescaler is parked on its last count.
    assign tick_int = en && (presc_q == PRESC_LAST);

    always_comb begin
        presc_d       = presc_q;
        pwm_cnt_d     = pwm_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        if (en) begin
            presc_d = tick_int ? '0 : presc_q + 1'b1;
        end

        if (tick_int) begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign tick        = tick_int;
    assign pwm_cnt     = pwm_cnt_q;
    assign blink_phase = blink_phase_q;

endmodule

// File: rtl/led_status_ctrl.sv
// Multi-channel LED indicator controller.
// Each of NUM_LEDS channels runs OFF, ON, BLINK or PWM from a shared
// timebase (led_tick_gen).
// Ports: clk, reset (async active-low), en (global enable),
//        cfg (write/readback port, slave side),
//        tick (exported prescaler tick), LED (registered drive, 1 = lit).
module led_status_ctrl import led_ctrl_pkg::*; #(
    parameter int NUM_LEDS    = 4,
    parameter int PRESCALE    = 50000,
    parameter int PWM_W       = 8,
    parameter int BLINK_TICKS = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    led_status_ctrl_if.slave    cfg,
    output logic                tick,
    output logic [NUM_LEDS-1:0] LED
);

    led_mode_t [NUM_LEDS-1:0]            mode_q, mode_d;
    logic      [NUM_LEDS-1:0][PWM_W-1:0] duty_q, duty_d;
    logic      [NUM_LEDS-1:0]            led_q, led_d;
    logic                                wr_err_q, wr_err_d;
    logic                                wr_in_range;
    logic      [PWM_W-1:0]               pwm_cnt;
    logic                                blink_phase;

    led_tick_gen #(
        .PRESCALE    (PRESCALE),
        .PWM_W       (PWM_W),
        .BLINK_TICKS (BLINK_TICKS)
    ) u_tick_gen (
        .clk         (clk),
        .rst_n       (reset),
        .en          (en),
        .tick        (tick),
        .pwm_cnt     (pwm_cnt),
        .blink_phase (blink_phase)
    );

    // The select is wider than needed when NUM_LEDS is not a power of two,
    // so an explicit range check guards the register arrays.
    assign wr_in_range = (int'(cfg.wr_ch) < NUM_LEDS);

    always_comb begin
        mode_d   = mode_q;
        duty_d   = duty_q;
        wr_err_d = 1'b0;
        if (cfg.wr_en) begin
            if (wr_in_range) begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (int'(cfg.wr_ch) == i) begin
                        mode_d[i] = cfg.wr_mode;
                        duty_d[i] = cfg.wr_duty;
                    end
                end
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

    // Computed from the registered config, so a write lands on the pins one
    // edge after it is captured, together with any counter update.
    always_comb begin
        led_d = '0;
        if (en) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                case (mode_q[i])
                    MODE_OFF:   led_d[i] = 1'b0;
                    MODE_ON:    led_d[i] = 1'b1;
                    MODE_BLINK: led_d[i] = blink_phase;
                    MODE_PWM:   led_d[i] = (pwm_cnt < duty_q[i]);
                    default:    led_d[i] = 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        cfg.rd_mode = MODE_OFF;
        cfg.rd_duty = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (int'(cfg.rd_ch) == i) begin
                cfg.rd_mode = mode_q[i];
                cfg.rd_duty = duty_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q   <= '0;
            duty_q   <= '0;
            led_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            duty_q   <= duty_d;
            led_q    <= led_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign cfg.wr_err = wr_err_q;
    assign LED        = led_q;

endmodule
